uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters with round-robin arbitration at packet granularity.
- The winning requester keeps the grant until it hands over a byte marked Last, so packets from different requesters never interleave on Tx.
- Sits between the client logic and the UART transmitter. Issues one TxStart pulse per byte and paces on TxBusy.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width carried to the transmitter
- TIMEOUT_CYCLES, 1_000_000, idle-cycle limit inside a packet (used only with the optional feature)

Ports:
- Clk  input  1  system clock
- Reset  input  1  asynchronous, active-high reset
- ReqValid  input  NUM_REQ  per-requester byte valid
- ReqData  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W]
- ReqLast  input  NUM_REQ  byte is the last of its packet
- ReqReady  output  NUM_REQ  one-hot byte accept, single-cycle pulse
- TxData  output  DATA_W  byte presented to the transmitter
- TxStart  output  1  single-cycle start pulse to the transmitter
- TxBusy  input  1  transmitter busy; rises the cycle after TxStart and falls after the stop bit
- GrantId  output  $clog2(NUM_REQ)  index of the current owner
- GrantValid  output  1  a packet is in progress
- TimeoutErr  output  1  sticky timeout flag (tied 0 without the optional feature)

Behaviour:
- Reset is asynchronous and active-high. While Reset is high:
  - ReqReady, TxStart, GrantValid and TimeoutErr are 0; TxData and GrantId are 0.
  - The round-robin pointer is 0 and the FSM is in IDLE.
- A Reset mid-packet drops the grant immediately. The transmitter is not aborted. After release, the FSM waits in IDLE until TxBusy is 0 before it arbitrates again.
- IDLE: if any ReqValid and TxBusy == 0, go to ARB.
- ARB (1 cycle):
  - Pick the first set ReqValid bit, scanning upward from the pointer and wrapping modulo NUM_REQ.
  - Register GrantId and set GrantValid = 1. Go to SEND.
  - If no request remains, return to IDLE.
- SEND:
  - If ReqValid[GrantId] and TxBusy == 0: drive TxData = requester byte, TxStart = 1 and ReqReady[GrantId] = 1, all in the same cycle; latch Last. Go to WAIT_ACK.
  - Otherwise hold in SEND.
  - A requester that deasserts Valid mid-packet keeps the grant.
- WAIT_ACK: wait for TxBusy = 1, then go to WAIT_DONE. This prevents a double start in the cycle after TxStart.
- WAIT_DONE: on TxBusy falling to 0:
  - If the latched Last is 1: set GrantValid = 0, pointer = GrantId+1 (wraps NUM_REQ-1 to 0), go to IDLE.
  - Otherwise go to SEND.
- Latency: grant to first TxStart is 2 cycles minimum (ARB, then SEND). A back-to-back byte's TxStart comes 1 cycle after TxBusy falls.
- TxData is registered and holds its last value between starts.
- At most one ReqReady bit is ever set. ReqReady never coincides with TxBusy = 1.
- A requester asserting Valid while not granted sees no response; its data must stay stable until accepted.
- Fairness: the just-served index has lowest priority in the next ARB. With all requesters valid and single-byte packets, grants run 0,1,2,3,0,...

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle in SEND while ReqValid[GrantId] == 0.
  - On reaching TIMEOUT_CYCLES: set TimeoutErr (sticky until Reset), release the grant, advance the pointer and go to IDLE.
  - The counter clears on every accepted byte.
- Undefined: no counter; TimeoutErr is constant 0 and a stalled owner holds the grant indefinitely.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding: IDLE, ARB, SEND, WAIT_ACK, WAIT_DONE.
  - UART_DATA_W = 8.
  - Default TIMEOUT_CYCLES.
- One natural sub-module, rr_arbiter: a combinational round-robin priority pick from the request vector and pointer, producing index and found flag.

Test Plan:
- Single packet: requester 2 sends 0x41, 0x42 (Last), with a TxBusy model of 10 cycles.
  - Two TxStart pulses with TxData 0x41 then 0x42, GrantId = 2 throughout, GrantValid falls after the second byte's TxBusy drops.
- Round-robin: all 4 requesters valid with single-byte Last packets 0xA0..0xA3.
  - TxData order 0xA0, 0xA1, 0xA2, 0xA3, then 0xA0 again when requester 0 re-requests.
- No interleave: requester 1 sends a 3-byte packet while requester 0 is valid throughout.
  - All 3 bytes of requester 1 go out before any byte of requester 0.
- Pacing: hold TxBusy high 20 cycles after each start.
  - Exactly one TxStart per byte and none while TxBusy = 1 or in the cycle right after TxStart.
- Reset mid-packet: assert Reset during WAIT_DONE.
  - Outputs return to reset values immediately. After release, no TxStart until TxBusy = 0 and a new request arrives.
- Timeout (macro defined, TIMEOUT_CYCLES = 50): owner drops Valid after byte 1 with Last = 0.
  - TimeoutErr = 1 after 50 idle cycles, and the next requester is granted.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit arbiter:
//                FSM state encoding, default byte width, default packet
//                timeout and the round-robin pointer advance helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W            = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_e;

    // Index following idx in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Bundle of requester byte streams, transmitter handshake and
//                grant status. The slave modport is the arbiter's view; the
//                master modport is the clients/transmitter side.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic [ID_W-1:0]           grant_id;
    logic                      grant_valid;
    logic                      timeout_err;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, grant_valid, timeout_err
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, grant_valid, timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Returns the first set
//                request bit at or above the pointer, wrapping modulo N,
//                plus a flag telling whether any request was set.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);
    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    // Rotate so that the pointer position lands on bit 0.
    assign w_rot = N'({req_i, req_i} >> ptr_i);

    // Lowest set bit of the rotated vector is the winner's offset from ptr.
    always_comb begin
        found_o = 1'b0;
        w_off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                found_o = 1'b1;
                w_off   = IDX_W'(k);
            end
        end
    end

    // Undo the rotation: ptr + offset, modulo N.
    assign w_sum = {1'b0, ptr_i} + {1'b0, w_off};
    assign idx_o = (w_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_sum - (IDX_W+1)'(N))
                                            : w_sum[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter between NUM_REQ byte-stream
//                requesters with packet-granular round-robin arbitration.
//                The owner keeps the grant until its Last byte completes.
//                Optional feature macro: UART_TX_ARB_TIMEOUT_EN (releases a
//                stalled owner after TIMEOUT_CYCLES and sets a sticky flag).
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = UART_DATA_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("uart_tx_arbiter: parameter out of range");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              grant_valid_q, grant_valid_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    logic [ID_W-1:0]   w_pick_idx;
    logic              w_pick_found;
    logic [DATA_W-1:0] w_bytes [NUM_REQ];
    logic              w_own_valid;
    logic              w_own_last;
    logic [DATA_W-1:0] w_own_byte;
    logic [ID_W-1:0]   w_ptr_next;
    logic              w_start;
    logic [NUM_REQ-1:0] w_ready;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_bytes[g] = bus.req_data[g*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .idx_o   (w_pick_idx),
        .found_o (w_pick_found)
    );

    assign w_own_valid = bus.req_valid[grant_id_q];
    assign w_own_last  = bus.req_last[grant_id_q];
    assign w_own_byte  = w_bytes[grant_id_q];
    // Just-served requester drops to lowest priority on the next arbitration.
    assign w_ptr_next  = ID_W'(rr_next(int'(grant_id_q), NUM_REQ));

    // Next-state, grant bookkeeping and the start/accept strobes.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        last_d        = last_q;
        tx_data_d     = tx_data_q;
        w_start       = 1'b0;
        w_ready       = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Also covers a reset that left the transmitter mid-byte.
                if ((|bus.req_valid) && !bus.tx_busy) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (w_pick_found) begin
                    grant_id_d    = w_pick_idx;
                    grant_valid_d = 1'b1;
                    state_d       = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_own_valid && !bus.tx_busy) begin
                    w_start    = 1'b1;
                    w_ready    = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;
                    tx_data_d  = w_own_byte;
                    last_d     = w_own_last;
                    state_d    = ST_WAIT_ACK;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (!w_own_valid) begin
                    if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err_d = 1'b1;
                        grant_valid_d = 1'b0;
                        ptr_d         = w_ptr_next;
                        tmo_cnt_d     = '0;
                        state_d       = ST_IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
`endif
            end
            ST_WAIT_ACK: begin
                // Busy only rises the cycle after the start; waiting here
                // keeps SEND from issuing a second start on a stale Busy=0.
                if (bus.tx_busy) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        grant_valid_d = 1'b0;
                        ptr_d         = w_ptr_next;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Main state and grant registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            last_q        <= 1'b0;
            tx_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            last_q        <= last_d;
            tx_data_q     <= tx_data_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Stall counter and sticky timeout flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // The accepted byte is steered straight through in the start cycle so
    // the transmitter sees it with TxStart; the register holds it after.
    assign bus.tx_data     = w_start ? w_own_byte : tx_data_q;
    assign bus.tx_start    = w_start;
    assign bus.req_ready   = w_ready;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = grant_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter with a
//                fixed-length TxBusy transmitter model and per-requester
//                byte queues (bit 8 of each entry is the Last flag).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ        (NR),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Requester drive
    logic [NR-1:0]    tb_valid = '0;
    logic [NR*DW-1:0] tb_data  = '0;
    logic [NR-1:0]    tb_last  = '0;
    assign bus.req_valid = tb_valid;
    assign bus.req_data  = tb_data;
    assign bus.req_last  = tb_last;
    logic [8:0] rq [NR][$];

    // Transmitter model: busy for busy_len cycles starting the cycle after TxStart
    int busy_len = 10;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (bus.tx_start)      busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0);

    // Monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [7:0] log_data [$];
    int         log_id   [$];
    int         log_cyc  [$];
    int         gvrise   [$];
    int pace_viol = 0, rdy_cnt = 0, rdy_viol = 0, gvfall_viol = 0;
    logic prev_start = 1'b0, prev_gv = 1'b0;
    always @(negedge clk) begin
        if (bus.tx_start) begin
            log_data.push_back(bus.tx_data);
            log_id.push_back(int'(bus.grant_id));
            log_cyc.push_back(cyc);
        end
        if (bus.tx_start && (bus.tx_busy || prev_start)) pace_viol <= pace_viol + 1;
        if (bus.req_ready != '0) begin
            rdy_cnt <= rdy_cnt + 1;
            if ($countones(bus.req_ready) != 1 || bus.tx_busy || !bus.tx_start)
                rdy_viol <= rdy_viol + 1;
        end
        if (prev_gv && !bus.grant_valid && bus.tx_busy && !rst) gvfall_viol <= gvfall_viol + 1;
        if (!prev_gv && bus.grant_valid) gvrise.push_back(cyc);
        prev_start <= bus.tx_start;
        prev_gv    <= bus.grant_valid;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic drive_reqs();
        logic [8:0] head;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                head = rq[i][0];
                tb_valid[i]        = 1'b1;
                tb_data[i*DW +: DW] = head[7:0];
                tb_last[i]         = head[8];
            end else begin
                tb_valid[i] = 1'b0;
                tb_last[i]  = 1'b0;
            end
        end
    endtask

    // One cycle: see ReqReady mid-cycle, pop accepted bytes after the edge.
    task automatic step();
        logic [NR-1:0] rdy;
        @(negedge clk);
        rdy = bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (rdy[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        drive_reqs();
    endtask

    task automatic clear_logs();
        log_data.delete(); log_id.delete(); log_cyc.delete(); gvrise.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        drive_reqs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic run_until_idle(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            step();
            if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
                rq[3].size() == 0 && !bus.grant_valid && !bus.tx_busy) done = 1'b1;
        end
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL %s_timeout: got not idle, want idle within 3000 cycles", name); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
        n_tests++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", bus.tx_start); end
        n_tests++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rst_gv: got %b want 0", bus.grant_valid); end
        n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.timeout_err); end
        n_tests++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_txdata: got %h want 00", bus.tx_data); end
        n_tests++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_gid: got %0d want 0", bus.grant_id); end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_single_packet();
        int r0 = rdy_cnt, rv0 = rdy_viol, p0 = pace_viol, g0 = gvfall_viol;
        do_reset();
        busy_len = 10;
        rq[2].push_back(9'h041);
        rq[2].push_back(9'h142);
        drive_reqs();
        run_until_idle("single");
        n_tests++; if (log_data.size() != 2) begin n_fail++; $display("FAIL single_count: got %0d want 2", log_data.size()); end
        n_tests++; if (log_data[0] !== 8'h41 || log_data[1] !== 8'h42) begin n_fail++; $display("FAIL single_data: got %h %h want 41 42", log_data[0], log_data[1]); end
        n_tests++; if (log_id[0] != 2 || log_id[1] != 2) begin n_fail++; $display("FAIL single_gid: got %0d %0d want 2 2", log_id[0], log_id[1]); end
        n_tests++; if (log_cyc[0] - gvrise[0] != 0) begin n_fail++; $display("FAIL single_first_latency: got %0d want 0", log_cyc[0] - gvrise[0]); end
        n_tests++; if (log_cyc[1] - log_cyc[0] != 12) begin n_fail++; $display("FAIL single_b2b_spacing: got %0d want 12", log_cyc[1] - log_cyc[0]); end
        n_tests++; if (rdy_cnt - r0 != 2 || rdy_viol != rv0) begin n_fail++; $display("FAIL single_ready: got %0d pulses %0d bad want 2 0", rdy_cnt - r0, rdy_viol - rv0); end
        n_tests++; if (gvfall_viol != g0 || pace_viol != p0) begin n_fail++; $display("FAIL single_gv_pace: got %0d %0d want 0 0", gvfall_viol - g0, pace_viol - p0); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        int         exp_i [5] = '{0, 1, 2, 3, 0};
        do_reset();
        busy_len = 3;
        rq[0].push_back(9'h1A0); rq[0].push_back(9'h1A0);
        rq[1].push_back(9'h1A1);
        rq[2].push_back(9'h1A2);
        rq[3].push_back(9'h1A3);
        drive_reqs();
        run_until_idle("rr");
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (log_data[k] !== exp_d[k] || log_id[k] != exp_i[k]) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %h id %0d want %h id %0d", k, log_data[k], log_id[k], exp_d[k], exp_i[k]);
            end
        end
    endtask

    task automatic test_no_interleave();
        logic [7:0] exp_d [4] = '{8'h10, 8'h11, 8'h12, 8'h05};
        int         exp_i [4] = '{1, 1, 1, 0};
        do_reset();
        busy_len = 4;
        rq[1].push_back(9'h010); rq[1].push_back(9'h011); rq[1].push_back(9'h112);
        drive_reqs();
        for (int c = 0; c < 200 && log_data.size() < 1; c++) step();
        rq[0].push_back(9'h105);
        drive_reqs();
        run_until_idle("interleave");
        n_tests++; if (log_data.size() != 4) begin n_fail++; $display("FAIL nointl_count: got %0d want 4", log_data.size()); end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (log_data[k] !== exp_d[k] || log_id[k] != exp_i[k]) begin
                n_fail++; $display("FAIL nointl_order[%0d]: got %h id %0d want %h id %0d", k, log_data[k], log_id[k], exp_d[k], exp_i[k]);
            end
        end
    endtask

    task automatic test_pacing();
        int p0 = pace_viol, r0 = rdy_cnt, rv0 = rdy_viol;
        do_reset();
        busy_len = 20;
        rq[3].push_back(9'h030); rq[3].push_back(9'h031); rq[3].push_back(9'h132);
        drive_reqs();
        run_until_idle("pacing");
        n_tests++; if (log_data.size() != 3) begin n_fail++; $display("FAIL pace_count: got %0d want 3", log_data.size()); end
        n_tests++; if (pace_viol != p0) begin n_fail++; $display("FAIL pace_busy_start: got %0d want 0", pace_viol - p0); end
        n_tests++; if (rdy_cnt - r0 != 3 || rdy_viol != rv0) begin n_fail++; $display("FAIL pace_ready: got %0d pulses %0d bad want 3 0", rdy_cnt - r0, rdy_viol - rv0); end
        n_tests++; if (log_cyc[1] - log_cyc[0] != 22 || log_cyc[2] - log_cyc[1] != 22) begin n_fail++; $display("FAIL pace_spacing: got %0d %0d want 22 22", log_cyc[1] - log_cyc[0], log_cyc[2] - log_cyc[1]); end
    endtask

    task automatic test_reset_mid_packet();
        int p0;
        do_reset();
        busy_len = 10;
        rq[2].push_back(9'h050); rq[2].push_back(9'h151);
        drive_reqs();
        for (int c = 0; c < 200 && log_data.size() < 1; c++) step();
        repeat (3) step();
        p0 = pace_viol;
        rst = 1'b1;
        #1;
        n_tests++; if (bus.grant_valid !== 1'b0 || bus.req_ready !== 4'b0 || bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got gv %b rdy %b st %b want 0 0 0", bus.grant_valid, bus.req_ready, bus.tx_start); end
        n_tests++; if (bus.tx_data !== 8'h00 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL midrst_data: got %h id %0d want 00 0", bus.tx_data, bus.grant_id); end
        for (int i = 0; i < NR; i++) rq[i].delete();
        drive_reqs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rq[1].push_back(9'h161);
        drive_reqs();
        repeat (2) step();
        n_tests++; if (bus.grant_valid !== 1'b0 || !bus.tx_busy) begin n_fail++; $display("FAIL midrst_wait_busy: got gv %b busy %b want 0 1", bus.grant_valid, bus.tx_busy); end
        run_until_idle("midrst");
        n_tests++; if (log_data.size() != 2 || log_data[1] !== 8'h61 || log_id[1] != 1) begin n_fail++; $display("FAIL midrst_resume: got %0d starts last %h id %0d want 2 61 1", log_data.size(), log_data[log_data.size()-1], log_id[log_id.size()-1]); end
        n_tests++; if (pace_viol != p0) begin n_fail++; $display("FAIL midrst_start_busy: got %0d want 0", pace_viol - p0); end
    endtask

    task automatic test_timeout();
        do_reset();
        busy_len = 3;
        rq[0].push_back(9'h070);
        drive_reqs();
        for (int c = 0; c < 200 && log_data.size() < 1; c++) step();
        rq[1].push_back(9'h181);
        drive_reqs();
`ifdef UART_TX_ARB_TIMEOUT_EN
        run_until_idle("timeout");
        n_tests++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", bus.timeout_err); end
        n_tests++; if (log_data.size() != 2 || log_data[1] !== 8'h81 || log_id[1] != 1) begin n_fail++; $display("FAIL tmo_next_grant: got %0d starts %h id %0d want 2 81 1", log_data.size(), log_data[1], log_id[1]); end
`else
        repeat (100) step();
        n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_off: got %b want 0", bus.timeout_err); end
        n_tests++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0 || log_data.size() != 1) begin n_fail++; $display("FAIL tmo_hold: got gv %b id %0d starts %0d want 1 0 1", bus.grant_valid, bus.grant_id, log_data.size()); end
        do_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_no_interleave();
        test_pacing();
        test_reset_mid_packet();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
